spi_arb: RTL and testbench

SPI_ARB -- requirements
Module: spi_arb

---
 rtl/spi_arb_pkg.sv | 21 ++
 rtl/spi_arb_rr.sv | 34 +++
 rtl/spi_arb.sv | 179 +++++++++++++++++
 tb/tb_spi_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the two-requester SPI register arbiter.
package spi_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One latched register command: direction, address and write byte.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/spi_arb_rr.sv
// Two-way round-robin grant. The last-grant register starts at 1 so that
// requester 0 wins the first contention after reset.
module spi_arb_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       gnt_any,
  output logic       gnt_idx
);

  logic last_reg;

  // Remember who was served last; updated once per completed transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (upd) begin
      last_reg <= upd_idx;
    end
  end

  // Under contention the requester not served last wins; otherwise the lone one.
  always_comb begin
    gnt_any = |req;
    if (req == 2'b11) begin
      gnt_idx = ~last_reg;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/spi_arb.sv
// Arbitrates two register-access requesters onto a single SPI core.
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYC cycles, completing the command with reqk_err=1.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              spi_wr_req,
  output logic [ADDR_W-1:0] spi_wr_addr,
  output logic [DATA_W-1:0] spi_wr_data,
  output logic              spi_rd_req,
  output logic [ADDR_W-1:0] spi_rd_addr,
  input  logic              spi_wr_end,
  input  logic              spi_rd_end,
  input  logic [DATA_W-1:0] spi_rd_data,
  output logic              busy
);

  state_t            state_reg, state_next;
  cmd_t              cmd_reg, sel_cmd;
  logic              cur_reg;
  logic              wr_req_reg, rd_req_reg;
  logic [DATA_W-1:0] rdata0_reg, rdata1_reg;
  logic              gnt_any, gnt_idx;
  logic              rr_upd;
  logic              accept;
  logic              end_match;
  logic              timeout_hit;

  spi_arb_rr u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_valid, req0_valid}),
    .upd     (rr_upd),
    .upd_idx (cur_reg),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  assign sel_cmd   = gnt_idx ? {req1_rw, req1_addr, req1_wdata}
                             : {req0_rw, req0_addr, req0_wdata};
  assign accept    = req0_ready | req1_ready;
  // Only the end pulse matching the latched direction completes a command.
  assign end_match = cmd_reg.rw ? spi_wr_end : spi_rd_end;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, handshake and completion decode.
  always_comb begin
    state_next = state_reg;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    req0_done  = 1'b0;
    req1_done  = 1'b0;
    rr_upd     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gnt_any) begin
          state_next = ISSUE;
          req0_ready = ~gnt_idx;
          req1_ready = gnt_idx;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (end_match || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        rr_upd     = 1'b1;
        req0_done  = ~cur_reg;
        req1_done  = cur_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the granted command and launch the one-cycle SPI start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_reg    <= '0;
      cur_reg    <= 1'b0;
      wr_req_reg <= 1'b0;
      rd_req_reg <= 1'b0;
    end else begin
      wr_req_reg <= accept & sel_cmd.rw;
      rd_req_reg <= accept & ~sel_cmd.rw;
      if (accept) begin
        cmd_reg <= sel_cmd;
        cur_reg <= gnt_idx;
      end
    end
  end

  // Capture read data for the owning requester as the read ends; writes
  // and aborted reads leave the held value alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_reg <= '0;
      rdata1_reg <= '0;
    end else if (state_reg == WAIT && !cmd_reg.rw && spi_rd_end) begin
      if (cur_reg) begin
        rdata1_reg <= spi_rd_data;
      end else begin
        rdata0_reg <= spi_rd_data;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             err_reg;

  assign timeout_hit = (state_reg == WAIT) &&
                       (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

  // WAIT-cycle counter, cleared on the way into WAIT; error flag records
  // whether WAIT was left by timeout rather than by the end pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else if (state_reg == ISSUE) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else if (state_reg == WAIT) begin
      tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
      err_reg     <= timeout_hit & ~end_match;
    end
  end

  assign req0_err = req0_done & err_reg;
  assign req1_err = req1_done & err_reg;
`else
  assign timeout_hit = 1'b0;
  assign req0_err    = 1'b0;
  assign req1_err    = 1'b0;
`endif

  assign req0_rdata  = rdata0_reg;
  assign req1_rdata  = rdata1_reg;
  assign spi_wr_req  = wr_req_reg;
  assign spi_rd_req  = rd_req_reg;
  assign spi_wr_addr = cmd_reg.addr;
  assign spi_wr_data = cmd_reg.wdata;
  assign spi_rd_addr = cmd_reg.addr;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb with an SPI-core model that ends each
// transaction 832 cycles after its start pulse.
module tb_spi_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 0, req0_rw = 0, req1_valid = 0, req1_rw = 0;
  logic [9:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_wdata = '0, req1_wdata = '0;
  logic       req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic [7:0] req0_rdata, req1_rdata;
  logic       spi_wr_req, spi_rd_req, spi_wr_end, spi_rd_end, busy;
  logic [9:0] spi_wr_addr, spi_rd_addr;
  logic [7:0] spi_wr_data, spi_rd_data;

  int n_vec = 0;
  int n_fail = 0;

  // SPI-core model state
  int         mdl_cnt = 0;
  logic       mdl_kind = 1'b0;
  logic       mdl_mute = 1'b0;
  logic       mdl_wr_end = 1'b0, mdl_rd_end = 1'b0;
  logic       inj_wr_end = 1'b0, inj_rd_end = 1'b0;
  logic [7:0] mdl_rdata = 8'h00;

  assign spi_wr_end  = mdl_wr_end | inj_wr_end;
  assign spi_rd_end  = mdl_rd_end | inj_rd_end;
  assign spi_rd_data = mdl_rdata;

  always #5 clk = ~clk;

  spi_arb #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .spi_wr_req(spi_wr_req), .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
    .spi_rd_req(spi_rd_req), .spi_rd_addr(spi_rd_addr),
    .spi_wr_end(spi_wr_end), .spi_rd_end(spi_rd_end), .spi_rd_data(spi_rd_data),
    .busy(busy)
  );

  // SPI core: end pulse lands in the 832nd cycle after the start pulse.
  always @(negedge clk) begin
    mdl_wr_end = 1'b0;
    mdl_rd_end = 1'b0;
    if (!rst_n) begin
      mdl_cnt = 0;
    end else begin
      if (mdl_cnt > 0) begin
        mdl_cnt = mdl_cnt - 1;
        if (mdl_cnt == 0 && !mdl_mute) begin
          if (mdl_kind) mdl_wr_end = 1'b1;
          else          mdl_rd_end = 1'b1;
        end
      end
      if (spi_wr_req || spi_rd_req) begin
        mdl_cnt  = 832;
        mdl_kind = spi_wr_req;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Steps until the requester's done pulse, bounded; k = cycles stepped.
  task automatic wait_done(input bit which, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (((which ? req1_done : req0_done) !== 1'b1) && k < 2000);
  endtask

  // Presents one command, checks it is accepted, and leaves the bench at
  // the ISSUE cycle with the request dropped.
  task automatic launch(input bit which, input bit rw, input logic [9:0] addr,
                        input logic [7:0] wd, input string tag);
    if (which) begin
      req1_valid = 1'b1; req1_rw = rw; req1_addr = addr; req1_wdata = wd;
    end else begin
      req0_valid = 1'b1; req0_rw = rw; req0_addr = addr; req0_wdata = wd;
    end
    #1;
    chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, which ? 32'd2 : 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int  k;
    int  g;
    int  dones;
    int  reqs;
    bit  last_g;
    bit  seen;

    // Reset state
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_outs", {req0_ready, req0_done, req0_err, req1_ready, req1_done,
                       req1_err, spi_wr_req, spi_rd_req}, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    $display("reset released, busy=%0b", busy);

    // req0 write 0x3FF / 0xA5
    launch(1'b0, 1'b1, 10'h3FF, 8'hA5, "t1");
    chk("t1_issue", {spi_wr_req, spi_rd_req, spi_wr_addr, spi_wr_data}, {1'b1, 1'b0, 10'h3FF, 8'hA5});
    step();
    chk("t1_pulse_width", {spi_wr_req, spi_rd_req, busy}, 3'b001);
    wait_done(1'b0, k);
    chk("t1_done_latency", k, 832);
    chk("t1_done_err", {req0_done, req0_err, req1_done}, 3'b100);
    chk("t1_addr_hold", {spi_wr_addr, spi_wr_data}, {10'h3FF, 8'hA5});
    step();
    chk("t1_idle", {busy, req0_done}, 0);
    $display("write req0 addr=3ff data=a5 done after %0d cycles", k + 1);

    // req1 read 0x037 returning 0x5C
    mdl_rdata = 8'h5C;
    launch(1'b1, 1'b0, 10'h037, 8'h00, "t2");
    chk("t2_issue", {spi_wr_req, spi_rd_req, spi_rd_addr}, {1'b0, 1'b1, 10'h037});
    wait_done(1'b1, k);
    chk("t2_done_latency", k, 833);
    chk("t2_rdata", {req1_done, req1_err, req1_rdata}, {1'b1, 1'b0, 8'h5C});
    chk("t2_req0_rdata_untouched", req0_rdata, 8'h00);
    step();
    $display("read req1 addr=037 rdata=%0h", req1_rdata);

    // Both requesters continuously valid, 4 commands each
    mdl_rdata  = 8'h77;
    req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 10'h010; req0_wdata = 8'h01;
    req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 10'h020; req1_wdata = 8'h00;
    g = 0; dones = 0; reqs = 0; last_g = 1'b0;
    for (int c = 0; c < 8000 && dones < 8; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("rr_grant", {req1_ready, req0_ready}, (g % 2 == 1) ? 32'd2 : 32'd1);
        last_g = req1_ready;
        $display("contention grant %0d -> req%0d", g, req1_ready);
        g++;
      end
      if (spi_wr_req || spi_rd_req) begin
        reqs++;
        chk("rr_no_overlap", reqs - dones, 1);
        chk("rr_req_kind", {spi_wr_req, spi_rd_req}, last_g ? 32'd1 : 32'd2);
      end
      if (req0_done || req1_done) begin
        chk("rr_done_owner", {req1_done, req0_done}, last_g ? 32'd2 : 32'd1);
        dones++;
      end
      step();
      if (g == 8) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    chk("rr_grant_count", g, 8);
    chk("rr_done_count", dones, 8);
    chk("rr_rdata", {req0_rdata, req1_rdata}, {8'h00, 8'h77});

    // End pulses while idle are ignored
    mdl_rdata  = 8'hEE;
    inj_wr_end = 1'b1; inj_rd_end = 1'b1;
    step();
    inj_wr_end = 1'b0; inj_rd_end = 1'b0;
    chk("idle_end_ignored", {busy, req0_done, req1_done}, 0);
    chk("idle_end_rdata", {req0_rdata, req1_rdata}, {8'h00, 8'h77});
    $display("idle end pulses ignored, busy=%0b", busy);

    // Write end injected during a read WAIT
    mdl_rdata = 8'h3C;
    launch(1'b0, 1'b0, 10'h100, 8'h00, "t4");
    repeat (10) step();
    inj_wr_end = 1'b1;
    step();
    inj_wr_end = 1'b0;
    chk("t4_wr_end_ignored", {busy, req0_done}, 2'b10);
    step();
    chk("t4_still_waiting", {busy, req0_done}, 2'b10);
    wait_done(1'b0, k);
    chk("t4_done_latency", k + 12, 833);
    chk("t4_rdata", req0_rdata, 8'h3C);
    step();
    $display("read req0 with stray wr_end rdata=%0h", req0_rdata);

`ifdef SPI_ARB_TIMEOUT_EN
    // Silent core: timeout after 100 WAIT cycles
    mdl_mute = 1'b1;
    launch(1'b1, 1'b0, 10'h055, 8'h00, "t5");
    wait_done(1'b1, k);
    chk("t5_timeout_latency", k, 101);
    chk("t5_err", {req1_done, req1_err}, 2'b11);
    chk("t5_rdata_kept", req1_rdata, 8'h77);
    step();
    mdl_mute = 1'b0;
    $display("timeout on req1 after %0d cycles", k);
    launch(1'b1, 1'b1, 10'h056, 8'h99, "t5b");
    chk("t5b_issue", {spi_wr_req, spi_wr_addr, spi_wr_data}, {1'b1, 10'h056, 8'h99});
    wait_done(1'b1, k);
    chk("t5b_done_latency", k, 833);
    chk("t5b_err", req1_err, 0);
    step();
`endif

    // Reset 400 cycles into a write
    launch(1'b0, 1'b1, 10'h2AA, 8'h11, "t6");
    repeat (400) step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_spi", {spi_wr_req, spi_rd_req, spi_wr_addr, spi_wr_data, spi_rd_addr}, 0);
    chk("t6_rst_req", {req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err}, 0);
    chk("t6_rst_rdata", {req0_rdata, req1_rdata}, 0);
    repeat (3) step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 900; c++) begin
      step();
      if (req0_done || req1_done || busy) seen = 1'b1;
    end
    chk("t6_no_done", seen, 0);
    launch(1'b0, 1'b1, 10'h155, 8'h66, "t6b");
    chk("t6b_issue", {spi_wr_req, spi_wr_addr, spi_wr_data}, {1'b1, 10'h155, 8'h66});
    wait_done(1'b0, k);
    chk("t6b_done_latency", k, 833);
    step();
    $display("post-reset write req0 done after %0d cycles", k + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
